lap_controller: RTL
===================

# lap_controller

Initiator for the stopwatch's 16×24-bit lap register file: captures the running BCD time on a lap request, writes it to the next free slot, and reads stored laps back for display on recall requests. It owns the register file's address, data, write-strobe and read-strobe lines and sequences each access as a multi-cycle strobe transaction. It sits between the button debouncers and time counter on one side and the register file plus display mux on the other.

## Interface
- DEPTH, 16: number of lap slots; must equal 2**AW
- AW, 4: register-file address width
- DW, 24: time word width (6 BCD digits, mm:ss:cc)

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- lap  in  1  one-cycle request to store time_in
- recall_next  in  1  one-cycle request to show the next stored lap
- recall_prev  in  1  one-cycle request to show the previous stored lap
- clear  in  1  one-cycle request to empty the lap memory
- time_in  in  DW  current stopwatch time
- rf_address  out  AW  register-file address
- rf_data  out  DW  register-file write data
- rf_wclk  out  1  register-file write strobe (rising edge writes)
- rf_rclk  out  1  register-file read strobe (rising edge loads the output)
- rf_q  in  DW  register-file read data
- lap_count  out  AW+1  number of stored laps, 0..DEPTH
- full  out  1  lap_count == DEPTH
- overflow  out  1  sticky: lap requested while full
- view_idx  out  AW  slot currently displayed
- view_time  out  DW  time of displayed slot
- view_valid  out  1  view_time holds a stored lap
- busy  out  1  state != IDLE

## Operation
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_CAPTURE.
- Arbitration in IDLE: clear > lap > recall_next > recall_prev. Only one request is accepted per cycle.
- clear: lap_count=0, overflow=0, view_valid=0, view_idx=0, all in one cycle, staying in IDLE. Register-file contents are not touched.
- Lap, not full: time_in is latched into rf_data on the acceptance edge, and rf_address=lap_count[AW-1:0]. Sequence is W_SETUP → W_STROBE (rf_wclk=1) → W_HOLD (rf_wclk=0) → IDLE.
  - On W_HOLD exit: lap_count+1, view_idx=written slot, view_time=rf_data, view_valid=1.
- Lap while full: nothing is written, overflow is set, and the state stays IDLE.
- Lap while busy: stored in a 1-deep pending flag. It is serviced on the first IDLE cycle and has priority over new recalls. A second lap arriving while the flag is set is dropped. clear also clears the pending flag.
- Recall with lap_count==0: ignored.
- recall_next: target = view_idx+1, wrapping from lap_count-1 to 0.
- recall_prev: target = view_idx−1, wrapping from 0 to lap_count-1.
- If view_valid==0, either recall targets slot 0.
- Recall sequence: R_SETUP (rf_address=target) → R_STROBE (rf_rclk=1) → R_CAPTURE (rf_rclk=0, sample rf_q) → IDLE, with view_time=rf_q, view_idx=target, view_valid=1.
- Recall requests arriving while busy are dropped.
- rf_address and rf_data are stable from SETUP through HOLD/CAPTURE. rf_wclk and rf_rclk are never high at the same time.

## Timing
- Reset (next edge with reset_n=0): state IDLE. All outputs 0: rf_address, rf_data, rf_wclk, rf_rclk, lap_count, full, overflow, view_idx, view_time, view_valid, busy. The pending flag is cleared.
- Reset mid-transaction forces both strobes low on that edge. A write aborted after W_STROBE does not increment lap_count.
- Write latency, with lap sampled at edge 0:
  - rf_address/rf_data valid from edge 1.
  - rf_wclk high in cycle 2 only.
  - lap_count and view_* updated at edge 4.
  - busy high cycles 1–3.
- Read latency, with recall sampled at edge 0:
  - rf_address valid from edge 1.
  - rf_rclk high in cycle 2 only.
  - rf_q sampled at edge 4; view_time valid from edge 4.
- Back-to-back laps with a pending flag: the second write's W_SETUP starts at edge 5, i.e. one IDLE cycle between transactions.
- full is combinational from lap_count and changes on the same edge.

## Structure
- Package lap_pkg: state enum, DEPTH/AW/DW defaults, BCD time word typedef.
- Single module. The FSM, pointers and view registers are small enough not to need a sub-module.

## Test plan
- Reset, then lap with time_in=24'h012345: rf_wclk high exactly in cycle 2 with rf_address=0 and rf_data=012345; lap_count=1 and view_time=012345 at edge 4.
- 16 laps, then a 17th: full=1 after the 16th, overflow=1, no rf_wclk pulse, lap_count stays 16; clear then gives lap_count=0 and overflow=0.
- With 3 laps stored (slots 0–2), view_idx=2:
  - recall_next reads slot 0 (wrap), and view_time equals the value the register-file model holds for slot 0.
  - recall_prev from slot 0 reads slot 2.
- lap asserted during R_STROBE: the read completes first, then the write starts with exactly one IDLE gap; a second lap during the same read is dropped.
- clear and lap in the same cycle: clear wins and no write occurs. recall with lap_count=0: busy stays 0 and no rf_rclk pulse.
- reset_n low during W_STROBE: rf_wclk=0 after that edge, lap_count=0, busy=0.

Source files
------------

// File: rtl/lap_pkg.sv
// Shared types and default geometry for the stopwatch lap controller.
package lap_pkg;

   localparam int LAP_DEPTH = 16;
   localparam int LAP_AW    = 4;
   localparam int LAP_DW    = 24;

   // Six packed BCD digits, mm:ss:cc
   typedef logic [LAP_DW-1:0] bcd_time_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_SETUP,
      S_W_STROBE,
      S_W_HOLD,
      S_R_SETUP,
      S_R_STROBE,
      S_R_CAPTURE
   } lap_state_t;

endpackage

// File: rtl/lap_controller.sv
// Lap register-file initiator: stores captured times on lap requests and
// reads them back for display on recall, as multi-cycle strobe transactions.
module lap_controller
   import lap_pkg::*;
#(
   parameter int DEPTH = LAP_DEPTH,
   parameter int AW    = LAP_AW,
   parameter int DW    = LAP_DW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          lap,
   input  logic          recall_next,
   input  logic          recall_prev,
   input  logic          clear,
   input  logic [DW-1:0] time_in,
   output logic [AW-1:0] rf_address,
   output logic [DW-1:0] rf_data,
   output logic          rf_wclk,
   output logic          rf_rclk,
   input  logic [DW-1:0] rf_q,
   output logic [AW:0]   lap_count,
   output logic          full,
   output logic          overflow,
   output logic [AW-1:0] view_idx,
   output logic [DW-1:0] view_time,
   output logic          view_valid,
   output logic          busy
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   lap_state_t    state_q, state_d;
   logic [AW-1:0] rf_address_q, rf_address_d;
   logic [DW-1:0] rf_data_q, rf_data_d;
   logic          rf_wclk_q, rf_wclk_d;
   logic          rf_rclk_q, rf_rclk_d;
   logic [AW:0]   lap_count_q, lap_count_d;
   logic          overflow_q, overflow_d;
   logic [AW-1:0] view_idx_q, view_idx_d;
   logic [DW-1:0] view_time_q, view_time_d;
   logic          view_valid_q, view_valid_d;
   logic          pending_q, pending_d;

   logic          is_full;
   logic          has_laps;
   logic [AW-1:0] last_idx;
   logic [AW-1:0] next_idx;
   logic [AW-1:0] prev_idx;

   always_comb begin
      is_full  = (lap_count_q == DEPTH_C);
      has_laps = (lap_count_q != '0);
      // Modular decrement also yields DEPTH-1 when the memory is full
      last_idx = lap_count_q[AW-1:0] - AW'(1);
      if (!view_valid_q || view_idx_q == last_idx) next_idx = '0;
      else                                         next_idx = view_idx_q + AW'(1);
      if (!view_valid_q)         prev_idx = '0;
      else if (view_idx_q == '0) prev_idx = last_idx;
      else                       prev_idx = view_idx_q - AW'(1);
   end

   always_comb begin
      state_d      = state_q;
      rf_address_d = rf_address_q;
      rf_data_d    = rf_data_q;
      rf_wclk_d    = 1'b0;
      rf_rclk_d    = 1'b0;
      lap_count_d  = lap_count_q;
      overflow_d   = overflow_q;
      view_idx_d   = view_idx_q;
      view_time_d  = view_time_q;
      view_valid_d = view_valid_q;
      pending_d    = pending_q;

      if (lap && state_q != S_IDLE) pending_d = 1'b1;
      if (clear) pending_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (clear) begin
               lap_count_d  = '0;
               overflow_d   = 1'b0;
               view_valid_d = 1'b0;
               view_idx_d   = '0;
            end else if (pending_q || lap) begin
               // A fresh lap arriving while the pending one is taken stays queued
               pending_d = pending_q && lap;
               if (is_full) begin
                  overflow_d = 1'b1;
               end else begin
                  state_d      = S_W_SETUP;
                  rf_address_d = lap_count_q[AW-1:0];
                  rf_data_d    = time_in;
               end
            end else if (recall_next && has_laps) begin
               state_d      = S_R_SETUP;
               rf_address_d = next_idx;
            end else if (recall_prev && has_laps) begin
               state_d      = S_R_SETUP;
               rf_address_d = prev_idx;
            end
         end
         S_W_SETUP: begin
            state_d   = S_W_STROBE;
            rf_wclk_d = 1'b1;
         end
         S_W_STROBE: state_d = S_W_HOLD;
         S_W_HOLD: begin
            state_d      = S_IDLE;
            lap_count_d  = lap_count_q + (AW+1)'(1);
            view_idx_d   = rf_address_q;
            view_time_d  = rf_data_q;
            view_valid_d = 1'b1;
         end
         S_R_SETUP: begin
            state_d   = S_R_STROBE;
            rf_rclk_d = 1'b1;
         end
         S_R_STROBE: state_d = S_R_CAPTURE;
         S_R_CAPTURE: begin
            state_d      = S_IDLE;
            view_idx_d   = rf_address_q;
            view_time_d  = rf_q;
            view_valid_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         rf_address_q <= '0;
         rf_data_q    <= '0;
         rf_wclk_q    <= 1'b0;
         rf_rclk_q    <= 1'b0;
         lap_count_q  <= '0;
         overflow_q   <= 1'b0;
         view_idx_q   <= '0;
         view_time_q  <= '0;
         view_valid_q <= 1'b0;
         pending_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rf_address_q <= rf_address_d;
         rf_data_q    <= rf_data_d;
         rf_wclk_q    <= rf_wclk_d;
         rf_rclk_q    <= rf_rclk_d;
         lap_count_q  <= lap_count_d;
         overflow_q   <= overflow_d;
         view_idx_q   <= view_idx_d;
         view_time_q  <= view_time_d;
         view_valid_q <= view_valid_d;
         pending_q    <= pending_d;
      end
   end

   assign rf_address = rf_address_q;
   assign rf_data    = rf_data_q;
   assign rf_wclk    = rf_wclk_q;
   assign rf_rclk    = rf_rclk_q;
   assign lap_count  = lap_count_q;
   assign full       = is_full;
   assign overflow   = overflow_q;
   assign view_idx   = view_idx_q;
   assign view_time  = view_time_q;
   assign view_valid = view_valid_q;
   assign busy       = (state_q != S_IDLE);

endmodule
